etpu_host_seq: RTL and testbench
================================

ETPU_HOST_SEQ -- requirements
Module: etpu_host_seq

Interface
REQ-001 Parameter RUN_LAT, default 9: cycles from the last weight word to the first result word on sa_out.
REQ-002 Parameter ACT_BEATS, default 3: number of 24-bit activation beats per job.
REQ-003 Parameter W_WORDS, default 5: number of 32-bit weight words per job.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 w_valid / w_ready / w_data  in / out / in  1/1/32  weight stream from host.
REQ-007 act_valid / act_ready / act_data  in / out / in  1/1/24  activation stream from host.
REQ-008 sa_data  out  32  weight word to the systolic array.
REQ-009 sa_input  out  24  activation to the systolic array.
REQ-010 sa_out  in  32  result words from the systolic array.
REQ-011 res_valid / res_ready / res_data / res_last  out / in / out / out  1/1/16/1  unpacked result stream.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, LOAD, RUN, COLLECT, DRAIN.
REQ-014 IDLE: w_ready=act_ready=0; moves to LOAD when w_valid=1 (the word itself is not consumed in IDLE).
REQ-015 LOAD: w_ready=1 until W_WORDS words are accepted; act_ready=1 until ACT_BEATS beats are buffered; each accepted word is driven on sa_data the cycle after its handshake.
REQ-016 LOAD does not stall the array: a cycle with no accepted weight word drives sa_data=0 and is not counted.
REQ-017 LOAD moves to RUN the cycle after the last weight word is accepted AND all activation beats are buffered; if weights finish first, sa_data holds 0 while waiting.
REQ-018 RUN: replays buffered activations on sa_input, beat 0 first, one beat per cycle; sa_input=0 after the last beat.
REQ-019 RUN lasts RUN_LAT cycles, then COLLECT.
REQ-020 COLLECT: captures sa_out on ceil(9/2)=5 consecutive cycles into a 9x16 result buffer: word k low half goes to result 2k, high half to result 2k+1; the high half of word 4 is discarded.
REQ-021 DRAIN: presents results 0..8 in order on res_data; res_valid=1; a beat advances only when res_valid&&res_ready; res_last=1 on result 8 only.
REQ-022 After result 8 is accepted the FSM returns to IDLE in the next cycle.
REQ-023 Results are raw 16-bit values (no sign extension or rounding); multi-cycle res_ready=0 holds res_data stable.
REQ-024 w_valid asserted outside LOAD is ignored (w_ready=0) and causes no state change except IDLE->LOAD.

Reset
REQ-025 On reset: state IDLE; sa_data=0, sa_input=0, res_valid=0, res_last=0, res_data=0, busy=0; w_ready=0, act_ready=0; all counters and the activation buffer cleared.
REQ-026 Reset in any state aborts the job in the next cycle; partial weights/results are discarded and no res_valid appears.

Configuration
REQ-027 Macro ETPU_JOB_CNT_EN: when defined, adds output job_cnt (16 bits, reset 0), incremented by 1 on each res_last handshake, wrapping 0xFFFF->0; when undefined the port and counter do not exist and all other behaviour is identical.

Structure
REQ-028 Shared package etpu_pkg holds the state enum, the result count (9), the result width (16) and the word width (32).
REQ-029 The activation buffer is a sub-module etpu_act_buf (ACT_BEATS-deep, write pointer, read pointer, clear).

Verification
REQ-030 Basic job: weights 0x01..0x05 and acts 0x010203, 0x040506, 0x070809 given back-to-back -> sa_data shows 0x01..0x05 on 5 consecutive cycles; sa_input shows the 3 acts in order; busy=1 throughout.
REQ-031 Unpack: sa_out=0xBBBBAAAA, then 0x2,0x3,0x4, then 0xDEAD1234 in COLLECT -> res_data sequence is 0xAAAA,0xBBBB,...,0x1234; res_last only on the 9th beat.
REQ-032 Backpressure: res_ready toggles 1,0,0,1 -> no result lost or duplicated; res_data stable while stalled.
REQ-033 Weight gaps: w_valid low for 2 cycles mid-load -> sa_data=0 on those cycles; RUN still starts only after the 5th word.
REQ-034 Reset mid-COLLECT -> next cycle IDLE, all outputs at reset values, no res_valid; a following job completes correctly.
REQ-035 With ETPU_JOB_CNT_EN: 3 complete jobs -> job_cnt=3; counter preset near wrap -> 0xFFFF wraps to 0.

Source files
------------

// File: rtl/etpu_pkg.sv
// Shared state encoding and result/word sizing for the eTPU host sequencer.
package etpu_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_COLLECT,
    ST_DRAIN
  } state_t;

  localparam int RES_CNT   = 9;
  localparam int RES_W     = 16;
  localparam int WORD_W    = 32;
  localparam int ACT_W     = 24;
  // Each array word carries two results, so an odd count leaves one half unused.
  localparam int COL_WORDS = (RES_CNT + 1) / 2;
endpackage

// File: rtl/etpu_act_buf.sv
// Activation buffer: DEPTH-deep store filled during load, replayed in order during run.
// Clear empties both pointers and the storage.
module etpu_act_buf
  import etpu_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_clear,
  input  logic                         i_wr_en,
  input  logic [ACT_W-1:0]             i_wr_data,
  input  logic                         i_rd_en,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic [ACT_W-1:0]             o_rd_data
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ACT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_full;
  logic             w_rd_vld;

  assign w_full   = (r_wr_ptr == PW'(DEPTH));
  assign w_rd_vld = (r_rd_ptr < r_wr_ptr);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr_en && !w_full) begin
        r_mem[r_wr_ptr[IW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (i_rd_en && w_rd_vld) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Reads past the last buffered beat return zero so the array sees idle input.
  assign o_rd_data = w_rd_vld ? r_mem[r_rd_ptr[IW-1:0]] : '0;
  assign o_full    = w_full;
  assign o_level   = r_wr_ptr;
endmodule

// File: rtl/etpu_host_seq.sv
// Host-side job sequencer: streams weights/activations into the systolic array, unpacks results.
// Defining ETPU_JOB_CNT_EN adds a wrapping 16-bit job_cnt output of completed jobs.
module etpu_host_seq
  import etpu_pkg::*;
#(
  parameter int RUN_LAT   = 9,
  parameter int ACT_BEATS = 3,
  parameter int W_WORDS   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [WORD_W-1:0] w_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [ACT_W-1:0]  act_data,
  output logic [WORD_W-1:0] sa_data,
  output logic [ACT_W-1:0]  sa_input,
  input  logic [WORD_W-1:0] sa_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_last,
`ifdef ETPU_JOB_CNT_EN
  output logic [15:0]       job_cnt,
`endif
  output logic              busy
);
  localparam int WCW  = $clog2(W_WORDS + 1);
  localparam int ABW  = $clog2(ACT_BEATS + 1);
  localparam int CMAX = (RUN_LAT > RES_CNT) ? RUN_LAT : RES_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RIW  = $clog2(RES_CNT);

  state_t            r_state;
  state_t            w_next;
  logic [WCW-1:0]    r_w_cnt;
  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_sa_data;
  logic [RES_W-1:0]  r_res [RES_CNT];
  logic              w_w_hs;
  logic              w_a_hs;
  logic              w_w_fin;
  logic              w_a_fin;
  logic              w_act_full;
  logic [ABW-1:0]    w_act_lvl;
  logic [ACT_W-1:0]  w_act_rd;
  logic              w_res_last;

  assign w_ready    = (r_state == ST_LOAD) && (r_w_cnt != WCW'(W_WORDS));
  assign act_ready  = (r_state == ST_LOAD) && !w_act_full;
  assign w_w_hs     = w_valid && w_ready;
  assign w_a_hs     = act_valid && act_ready;
  // Completion includes a handshake happening this cycle, so RUN follows it directly.
  assign w_w_fin    = (r_w_cnt == WCW'(W_WORDS)) || (w_w_hs && (r_w_cnt == WCW'(W_WORDS - 1)));
  assign w_a_fin    = w_act_full || (w_a_hs && (w_act_lvl == ABW'(ACT_BEATS - 1)));
  assign w_res_last = (r_cnt == CW'(RES_CNT - 1));
  assign sa_data    = r_sa_data;
  assign busy       = (r_state != ST_IDLE);

  etpu_act_buf #(.DEPTH(ACT_BEATS)) u_act_buf (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (r_state == ST_IDLE),
    .i_wr_en   (w_a_hs),
    .i_wr_data (act_data),
    .i_rd_en   (r_state == ST_RUN),
    .o_full    (w_act_full),
    .o_level   (w_act_lvl),
    .o_rd_data (w_act_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    sa_input  = '0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    res_data  = '0;
    case (r_state)
      ST_IDLE:    if (w_valid) w_next = ST_LOAD;
      ST_LOAD:    if (w_w_fin && w_a_fin) w_next = ST_RUN;
      ST_RUN: begin
        sa_input = w_act_rd;
        if (r_cnt == CW'(RUN_LAT - 1)) w_next = ST_COLLECT;
      end
      ST_COLLECT: if (r_cnt == CW'(COL_WORDS - 1)) w_next = ST_DRAIN;
      ST_DRAIN: begin
        res_valid = 1'b1;
        res_data  = r_res[r_cnt[RIW-1:0]];
        res_last  = w_res_last;
        if (res_ready && w_res_last) w_next = ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_cnt   <= '0;
      r_cnt     <= '0;
      r_sa_data <= '0;
      for (int j = 0; j < RES_CNT; j++) r_res[j] <= '0;
    end else begin
      r_sa_data <= w_w_hs ? w_data : '0;
      if (r_state == ST_IDLE) r_w_cnt <= '0;
      else if (w_w_hs)        r_w_cnt <= r_w_cnt + WCW'(1);
      // r_cnt is the per-state cycle/beat index and restarts on every state change.
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == ST_RUN || r_state == ST_COLLECT || (r_state == ST_DRAIN && res_ready))
        r_cnt <= r_cnt + CW'(1);
      if (r_state == ST_COLLECT) begin
        for (int j = 0; j < RES_CNT; j++)
          if (r_cnt == CW'(j / 2))
            r_res[j] <= (j % 2 == 0) ? sa_out[RES_W-1:0] : sa_out[2*RES_W-1:RES_W];
      end
    end
  end

`ifdef ETPU_JOB_CNT_EN
  logic [15:0] r_job_cnt;
  always_ff @(posedge clk) begin
    if (reset)                               r_job_cnt <= '0;
    else if (res_valid && res_ready && res_last) r_job_cnt <= r_job_cnt + 16'd1;
  end
  assign job_cnt = r_job_cnt;
`endif
endmodule

// File: tb/tb_etpu_host_seq.sv
// Randomized job-level bench for etpu_host_seq with a count/queue based reference model.
`timescale 1ns/1ps
module tb_etpu_host_seq;
  localparam int RUN_LAT = 9, ACT_BEATS = 3, W_WORDS = 5, NRES = 9, NCOL = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid, w_ready, act_valid, act_ready;
  logic [31:0] w_data, sa_data, sa_out;
  logic [23:0] act_data, sa_input;
  logic        res_valid, res_ready, res_last, busy;
  logic [15:0] res_data;
`ifdef ETPU_JOB_CNT_EN
  logic [15:0] job_cnt;
`endif

  always #5 clk = ~clk;

  etpu_host_seq #(.RUN_LAT(RUN_LAT), .ACT_BEATS(ACT_BEATS), .W_WORDS(W_WORDS)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .sa_data(sa_data), .sa_input(sa_input), .sa_out(sa_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
`ifdef ETPU_JOB_CNT_EN
    .job_cnt(job_cnt),
`endif
    .busy(busy)
  );

  int n_chk = 0, n_err = 0, jobs_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: random valids/ready; 1: directed data, no gaps, ready 1,0,0,1; 2: two-cycle weight gap
  task automatic run_job(input int mode, input bit abort);
    logic [31:0] wq [W_WORDS];
    logic [23:0] aq [ACT_BEATS];
    logic [31:0] rw [NCOL];
    logic [15:0] er [NRES];
    logic [31:0] sa_next;
    logic [23:0] exp_si;
    int nw = 0, na = 0, ri = 0, rs = -1, c = 0, gap = 0, post = -1, rph = 0;
    bit active = 0, load_done = 0, done = 0, in_load, in_drain, exp_wr, exp_ar;

    if (mode == 1) begin
      wq = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
      aq = '{24'h010203, 24'h040506, 24'h070809};
      rw = '{32'hBBBBAAAA, 32'h2, 32'h3, 32'h4, 32'hDEAD1234};
    end else begin
      for (int i = 0; i < W_WORDS; i++)   wq[i] = $urandom | 32'h1;
      for (int i = 0; i < ACT_BEATS; i++) aq[i] = 24'($urandom_range(1, 32'hFFFFFF));
      for (int i = 0; i < NCOL; i++)      rw[i] = $urandom;
    end
    for (int j = 0; j < NRES; j++) er[j] = 16'(rw[j / 2] >> (16 * (j % 2)));
    sa_next = '0;

    while (1) begin
      in_load  = active && !load_done;
      exp_wr   = in_load && (nw < W_WORDS);
      exp_ar   = in_load && (na < ACT_BEATS);
      in_drain = active && (rs >= 0) && (c >= rs + RUN_LAT + NCOL);
      exp_si   = (rs >= 0 && c >= rs && c < rs + ACT_BEATS) ? aq[c - rs] : '0;
      chk("busy",      32'(busy),      32'(active));
      chk("w_ready",   32'(w_ready),   32'(exp_wr));
      chk("act_ready", 32'(act_ready), 32'(exp_ar));
      chk("sa_data",   sa_data,        sa_next);
      chk("sa_input",  32'(sa_input),  32'(exp_si));
      chk("res_valid", 32'(res_valid), 32'(in_drain));
      chk("res_last",  32'(res_last),  32'(in_drain && ri == NRES - 1));
      if (in_drain)  chk("res_data", 32'(res_data), 32'(er[ri]));
      if (post == 3) chk("res_data_after_reset", 32'(res_data), 32'h0);
      if (done || post == 0) break;
      if (c > 400) begin
        chk("job_timeout", 32'(c), 32'h0);
        break;
      end

      reset     = 1'b0;
      res_ready = (mode == 1) ? (rph % 4 == 0 || rph % 4 == 3) : 1'($urandom_range(0, 1));
      sa_out    = (rs >= 0 && c >= rs + RUN_LAT && c < rs + RUN_LAT + NCOL) ? rw[c - rs - RUN_LAT] : $urandom;
      act_valid = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      act_data  = (na < ACT_BEATS) ? aq[na] : 24'($urandom);
      if (post >= 0 || in_drain)          w_valid = 1'b0;
      else if (!active)                   w_valid = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      else if (in_load && nw < W_WORDS) begin
        if (mode == 2 && nw == 2 && gap < 2) begin
          w_valid = 1'b0;
          gap++;
        end else w_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else                            w_valid = 1'($urandom_range(0, 1));
      w_data = !active ? wq[0] : ((nw < W_WORDS) ? wq[nw] : $urandom);
      if (abort && post < 0 && rs >= 0 && c == rs + RUN_LAT + 2) begin
        reset   = 1'b1;
        w_valid = 1'b0;
      end

      if (reset) begin
        active = 0; load_done = 0; rs = -1; sa_next = '0; post = 3;
      end else begin
        sa_next = (exp_wr && w_valid) ? w_data : '0;
        if (exp_wr && w_valid)   nw++;
        if (exp_ar && act_valid) na++;
        if (!active && w_valid && post < 0) active = 1;
        if (in_load && nw == W_WORDS && na == ACT_BEATS) begin
          load_done = 1;
          rs = c + 1;
        end
        if (in_drain) begin
          rph++;
          if (res_ready) begin
            ri++;
            if (ri == NRES) begin
              done = 1;
              active = 0;
              jobs_done++;
            end
          end
        end
        if (post > 0) post--;
      end
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    reset = 1'b1; w_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
    w_data = '0; act_data = '0; sa_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_w_ready",   32'(w_ready),   32'h0);
    chk("rst_act_ready", 32'(act_ready), 32'h0);
    chk("rst_sa_data",   sa_data,        32'h0);
    chk("rst_sa_input",  32'(sa_input),  32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_last",  32'(res_last),  32'h0);
    chk("rst_res_data",  32'(res_data),  32'h0);
`ifdef ETPU_JOB_CNT_EN
    chk("rst_job_cnt",   32'(job_cnt),   32'h0);
`endif
    reset = 1'b0;

    run_job(1, 0);
    run_job(2, 0);
    for (int k = 0; k < 4; k++) run_job(0, 0);
    run_job(0, 1);
    run_job(0, 0);
    run_job(1, 1);
    run_job(1, 0);

`ifdef ETPU_JOB_CNT_EN
    chk("job_cnt", 32'(job_cnt), 32'(jobs_done));
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
